// File: rtl/cpu_sequencer.sv
// Purpose: fetch/execute control unit for the 8-bit accumulator CPU (IR, PC, ALU strobes, memory handshake).
// Latency: 3 cycles per instruction with zero-wait memory; every mem_ready=0 cycle under mem_req adds one.
// Backpressure: stalls in place while mem_req is high and mem_ready low; WAIT_MAX+1 stalled cycles halt until reset.
module cpu_sequencer #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    input  logic              z,
    input  logic              c,
    output logic [7:0]        instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ldAcc,
    output logic              useAlu,
    output logic              dbusSelect,
    output logic              halted
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC_A = 2'd1,
        EXEC_B = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         ir;
    logic [WCW-1:0]     wait_cnt;
    logic [2:0]         op;
    logic [ADDR_W-1:0]  operand;
    logic               timeout;
    logic               c_unused;

    // The carry flag only matters to the ALU; branches here look at z alone.
    assign c_unused    = c;

    assign op          = ir[7:5];
    assign operand     = ir[ADDR_W-1:0];
    assign instruction = ir;
    assign timeout     = mem_req && !mem_ready && (wait_cnt == WCW'(WAIT_MAX));

    // Strobes and memory request decoded from state/IR/mem_ready; all silent in reset or after a bus error.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        ldAcc      = 1'b0;
        useAlu     = 1'b0;
        dbusSelect = 1'b0;
        if (!reset && !halted) begin
            case (state)
                FETCH: begin
                    mem_addr = pc;
                    mem_req  = run;
                end
                EXEC_A: begin
                    mem_addr = operand;
                    case (op)
                        OP_ADD, OP_SUB, OP_NAND: begin
                            mem_req = 1'b1;
                            useAlu  = mem_ready;
                        end
                        OP_LD: begin
                            mem_req = 1'b1;
                            ldAcc   = mem_ready;
                        end
                        OP_SHIFT: useAlu = 1'b1;
                        default: ;
                    endcase
                end
                EXEC_B: begin
                    mem_addr = operand;
                    if (op == OP_ST) begin
                        mem_req    = 1'b1;
                        mem_we     = 1'b1;
                        dbusSelect = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, PC/IR updates and the memory wait watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= 8'h00;
            wait_cnt <= '0;
            halted   <= 1'b0;
        end else if (!halted) begin
            if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else if (mem_req) begin
                wait_cnt <= '0;
            end

            case (state)
                FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= EXEC_A;
                    end
                end
                EXEC_A: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_NAND, OP_LD: begin
                            if (mem_ready) state <= EXEC_B;
                        end
                        OP_JMP: begin
                            pc    <= operand;
                            state <= EXEC_B;
                        end
                        OP_JZ: begin
                            if (z) pc <= operand;
                            state <= EXEC_B;
                        end
                        default: state <= EXEC_B;
                    endcase
                end
                EXEC_B: begin
                    if (op != OP_ST || mem_ready) state <= FETCH;
                end
                default: state <= FETCH;
            endcase

            // A stalled access past the limit overrides whatever the state machine chose.
            if (timeout) begin
                halted   <= 1'b1;
                state    <= FETCH;
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose: self-checking bench for cpu_sequencer: directed literal cases plus randomized program run.
// Latency: checks 3+waits cycles per instruction against an instruction-level reference model.
// Backpressure: bench memory inserts random mem_ready wait cycles; a dedicated case drives the wait limit.
module tb_cpu_sequencer;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mem_ready = 1'b0;
    logic       z = 1'b0;
    logic       c = 1'b0;
    logic [7:0] mem_rdata;
    logic [7:0] instruction;
    logic [4:0] pc;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic       ldAcc;
    logic       useAlu;
    logic       dbusSelect;
    logic       halted;

    logic [7:0] mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    cpu_sequencer #(
        .ADDR_W  (5),
        .RESET_PC(5'd0),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .z          (z),
        .c          (c),
        .instruction(instruction),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .ldAcc      (ldAcc),
        .useAlu     (useAlu),
        .dbusSelect (dbusSelect),
        .halted     (halted)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    // ---------------- instruction-level reference model ----------------
    // Event encoding {kind, addr}: 0 fetch, 1 ALU read, 2 LD read, 3 SHIFT, 4 store, 7 illegal.
    logic [7:0] expq [$];
    logic [4:0] mpc;
    int         cyc;
    int         wacc;
    int         waits;
    bit         first;

    task automatic model_step;
        logic [7:0] ir;
        ir = mem[mpc];
        expq.push_back({3'd0, mpc});
        mpc = mpc + 5'd1;
        case (ir[7:5])
            3'd0, 3'd1, 3'd2: expq.push_back({3'd1, ir[4:0]});
            3'd3:             expq.push_back({3'd3, 5'd0});
            3'd4:             expq.push_back({3'd2, ir[4:0]});
            3'd5:             expq.push_back({3'd4, ir[4:0]});
            3'd6:             mpc = ir[4:0];
            default:          if (z) mpc = ir[4:0];
        endcase
    endtask

    // Per-cycle compare of observed bus events against the model.
    task automatic check_cycle;
        logic [7:0] ev;
        logic [2:0] kind;
        bit         have_ev;
        cyc++;
        chk("strobe_onehot", int'($countones({ldAcc, useAlu, dbusSelect}) <= 1), 1);
        chk("we_without_dbus", int'(mem_we && !dbusSelect), 0);
        chk("no_halt", int'(halted), 0);
        have_ev = 1'b0;
        ev      = 8'h00;
        if (mem_req && !mem_ready) begin
            wacc++;
            waits--;
        end
        if (mem_req && mem_ready) begin
            have_ev = 1'b1;
            kind    = mem_we ? 3'd4 : ldAcc ? 3'd2 : useAlu ? 3'd1 : 3'd0;
            if (mem_we != dbusSelect) kind = 3'd7;
            ev      = {kind, mem_addr};
            waits   = $urandom_range(0, 3);
        end else if (useAlu || ldAcc || (dbusSelect && !mem_req)) begin
            have_ev = 1'b1;
            kind    = (useAlu && !mem_req && !ldAcc && !dbusSelect) ? 3'd3 : 3'd7;
            ev      = {kind, 5'd0};
        end
        if (have_ev) begin
            if (ev[7:5] == 3'd0) begin
                chk("fetch_pc", int'(pc), int'(mem_addr));
                if (!first) chk("instr_cycles", cyc, 3 + wacc);
                first = 1'b0;
                cyc   = 0;
                wacc  = 0;
                z     = 1'($urandom_range(0, 1));
            end
            if (expq.size() == 0) model_step;
            chk("bus_event", int'(ev), int'(expq.pop_front()));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         ld_cyc;
        int         alu_cyc;
        int         st_n;
        int         bad_addr;
        logic [7:0] acc;

        // 1: reset during EXEC_A of a store
        clear_mem;
        mem[0]    = 8'hA5;
        run       = 1'b1;
        mem_ready = 1'b1;
        do_reset;
        @(negedge clk);
        tick;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_strobes", int'({mem_req, mem_we, ldAcc, useAlu, dbusSelect}), 0);
        tick;
        @(negedge clk);
        chk("rst_ir", int'(instruction), 0);
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_fetch", int'({mem_req, mem_we, mem_addr}), int'({1'b1, 1'b0, 5'd0}));
        chk("rst_quiet", int'({ldAcc, useAlu, dbusSelect, halted}), 0);

        // 2: zero-wait LD 3 ; ADD 4
        clear_mem;
        mem[0] = 8'h83;
        mem[1] = 8'h04;
        mem[3] = 8'h9E;
        mem[4] = 8'h61;
        do_reset;
        acc     = 8'h00;
        ld_cyc  = 0;
        alu_cyc = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ldAcc) begin
                ld_cyc = k;
                acc    = mem_rdata;
            end
            if (useAlu) begin
                alu_cyc = k;
                if (instruction[7:5] == 3'd0) acc = acc + mem_rdata;
            end
            if (k == 6) chk("prog_pc", int'(pc), 2);
            tick;
        end
        chk("prog_ld_cycle", ld_cyc, 2);
        chk("prog_alu_cycle", alu_cyc, 5);
        chk("prog_acc", int'(acc), 8'hFF);

        // 3: store with 3 wait cycles
        clear_mem;
        mem[0] = 8'hA5;
        do_reset;
        st_n     = 0;
        bad_addr = 0;
        for (int k = 1; k <= 7; k++) begin
            mem_ready = !(k >= 3 && k <= 5);
            @(negedge clk);
            if (dbusSelect && mem_we && mem_req) begin
                st_n++;
                if (mem_addr != 5'd5) bad_addr++;
            end
            if (k == 7) chk("st_next_fetch", int'({mem_req, mem_we, mem_addr}), int'({1'b1, 1'b0, 5'd1}));
            tick;
        end
        chk("st_cycles", st_n, 4);
        chk("st_addr", bad_addr, 0);
        mem_ready = 1'b1;

        // 4: JZ taken / not taken
        clear_mem;
        mem[0] = 8'hF0;
        z = 1'b1;
        do_reset;
        tick;
        tick;
        @(negedge clk);
        chk("jz_taken_pc", int'(pc), 16);
        z = 1'b0;
        do_reset;
        tick;
        tick;
        @(negedge clk);
        chk("jz_not_taken_pc", int'(pc), 1);

        // 4/5: JMP to 31, fetch at 31 wraps pc, JMP 31 again
        clear_mem;
        mem[0]  = 8'hDF;
        mem[31] = 8'hDF;
        do_reset;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) chk("jmp_pc", int'(pc), 31);
            if (k == 4) chk("fetch31", int'({mem_req, mem_addr}), int'({1'b1, 5'd31}));
            if (k == 5) chk("pc_wrap", int'(pc), 0);
            if (k == 6) chk("jmp_self_pc", int'(pc), 31);
            tick;
        end

        // 5: run=0 holds FETCH; an instruction already started completes
        clear_mem;
        mem[0] = 8'h83;
        run = 1'b0;
        do_reset;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("run0_hold", int'({mem_req, pc}), 0);
            tick;
        end
        run = 1'b1;
        @(negedge clk);
        chk("run1_req", int'(mem_req), 1);
        tick;
        run = 1'b0;
        @(negedge clk);
        chk("run0_inflight_ld", int'(ldAcc), 1);
        tick;
        tick;
        @(negedge clk);
        chk("run0_after", int'({mem_req, pc}), int'({1'b0, 5'd1}));
        tick;

        // 6: mem_ready stuck low -> sticky halt
        clear_mem;
        run       = 1'b1;
        mem_ready = 1'b0;
        do_reset;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (halted) break;
            if (mem_req) n++;
            tick;
        end
        chk("halt_set", int'(halted), 1);
        chk("halt_req_cycles", n, WAIT_MAX + 1);
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            chk("halt_sticky", int'({halted, mem_req}), int'({1'b1, 1'b0}));
        end
        tick;
        do_reset;
        @(negedge clk);
        chk("halt_cleared", int'(halted), 0);
        tick;

        // Randomized program with random memory wait states
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        run       = 1'b1;
        z         = 1'b0;
        mem_ready = 1'b1;
        waits     = 0;
        do_reset;
        expq.delete();
        mpc   = 5'd0;
        first = 1'b1;
        cyc   = 0;
        wacc  = 0;
        for (int k = 0; k < 3000; k++) begin
            mem_ready = (waits == 0);
            @(negedge clk);
            check_cycle;
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
